wb2core: RTL and testbench

- Wishbone B4 pipelined slave that drives an Ibex-style memory responder port (req/gnt/rvalid/err), so existing core-protocol memories and peripherals can sit on the Wishbone fabric.
- Tracks outstanding transactions and stalls the bus when the limit is reached.
- Discards responses still owed to a cycle the master has abandoned.
- Sits between the interconnect and on-chip RAM/peripheral blocks.

---
 rtl/wb2core_pkg.sv | 20 ++
 rtl/wb2core.sv | 101 ++++++++++
 tb/tb_wb2core.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb2core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb2core_pkg : response kinds and counter-width helper for wb2core
// Rev 1.0
// ---------------------------------------------------------------------------
package wb2core_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_ACK  = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb2core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb2core : Wishbone B4 pipelined slave driving a req/gnt/rvalid memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module wb2core
  import wb2core_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [DW/8-1:0] wb_sel,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            wb_stall,
  output logic            wb_ack,
  output logic            wb_err,
  output logic [DW-1:0]   wb_dat_o,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_err
);

  localparam int CW = cnt_width(MaxOutstanding);
  localparam logic [CW-1:0] MAX_CNT = CW'(MaxOutstanding);

  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop, drop_nxt;
  logic [CW:0]   drop_sum;
  resp_e         resp, resp_nxt;
  logic          full, draining, accept, rsp_live, abort;

  assign mem_we    = wb_we;
  assign mem_be    = wb_sel;
  assign mem_addr  = wb_adr;
  assign mem_wdata = wb_dat_i;

  assign full     = (outstanding == MAX_CNT);
  assign draining = (drop != '0);
  assign mem_req  = wb_cyc & wb_stb & ~full & ~draining;
  assign wb_stall = full | draining | ~mem_gnt;
  assign accept   = mem_req & mem_gnt;
  assign rsp_live = mem_rvalid & ~draining;
  assign abort    = ~wb_cyc & (outstanding != '0);

  // On abort every still-owed response becomes a stale one; a response
  // arriving in that same cycle (live or stale) is consumed right away.
  assign drop_sum = {1'b0, drop} + {1'b0, outstanding} - (CW + 1)'(mem_rvalid);

  always_comb begin
    outstanding_nxt = outstanding;
    drop_nxt        = drop;
    resp_nxt        = RESP_NONE;
    if (abort) begin
      outstanding_nxt = '0;
      drop_nxt = (drop_sum > {1'b0, MAX_CNT}) ? MAX_CNT : drop_sum[CW-1:0];
    end else begin
      outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_live);
      if (mem_rvalid && draining) drop_nxt = drop - 1'b1;
    end
    if (rsp_live && wb_cyc) resp_nxt = mem_err ? RESP_ERR : RESP_ACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop        <= '0;
      resp        <= RESP_NONE;
      wb_dat_o    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      resp        <= resp_nxt;
      if (rsp_live) wb_dat_o <= mem_rdata;
    end
  end

  assign wb_ack = (resp == RESP_ACK);
  assign wb_err = (resp == RESP_ERR);

  a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> (({1'b0, outstanding} + {1'b0, drop}) != '0));
  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_ack && wb_err));
  a_outstanding_max: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= MAX_CNT);

endmodule
`default_nettype wire

// File: tb/tb_wb2core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb2core : randomized bench for wb2core with an in-order memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb2core;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_i;
  logic wb_stall, wb_ack, wb_err;
  logic [31:0] wb_dat_o;
  logic mem_req, mem_gnt, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  wb2core #(.AW(AW), .DW(DW), .MaxOutstanding(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_stall(wb_stall), .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_o(wb_dat_o),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } mem_rsp_t;

  mem_rsp_t memq[$];
  int   cyc_no = 0, last_due = -1;
  int   lat_min = 1, lat_max = 1, err_pct = 0;
  bit   use_fixed = 0, force_err = 0;
  logic [31:0] fixed_data = '0;

  // Reference view: responses owed to the live cycle, stale ones still due.
  int   owed = 0, stale = 0;
  logic [31:0] exp_dat = '0;
  bit   last_acc;
  int   ack_cnt = 0, err_cnt = 0;
  int   checks = 0, passes = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    bit rv, live, acc, exp_stall, exp_req, n_ack, n_err;
    logic [31:0] rdat;
    logic rerr;
    int owed0, lat;
    rv = 0; rdat = '0; rerr = 0;
    if (memq.size() > 0 && memq[0].due <= cyc_no) begin
      rv = 1; rdat = memq[0].data; rerr = memq[0].err;
    end
    mem_rvalid = rv;
    mem_rdata  = rv ? rdat : $urandom;
    mem_err    = rv ? rerr : 1'($urandom_range(1));
    #1;
    exp_stall = (owed == MAXO) || (stale != 0) || !mem_gnt;
    exp_req   = wb_cyc && wb_stb && (owed != MAXO) && (stale == 0);
    check("stall", wb_stall, exp_stall);
    check("mem_req", mem_req, exp_req);
    check("forward", {mem_we, mem_be, mem_addr, mem_wdata}, {wb_we, wb_sel, wb_adr, wb_dat_i});
    acc = wb_cyc && wb_stb && !exp_stall;
    last_acc = acc;
    live  = rv && (stale == 0);
    n_ack = live && wb_cyc && !rerr;
    n_err = live && wb_cyc && rerr;
    if (live) exp_dat = rdat;
    owed0 = owed;
    if (!wb_cyc && owed0 != 0) begin
      stale = stale + owed0 - int'(rv);
      if (stale > MAXO) stale = MAXO;
      owed = 0;
    end else begin
      owed = owed0 + int'(acc) - int'(live);
      if (rv && !live) stale--;
    end
    @(posedge clk);
    if (rv) void'(memq.pop_front());
    if (acc) begin
      mem_rsp_t r;
      lat = $urandom_range(lat_max, lat_min);
      r.due  = (cyc_no + lat > last_due) ? cyc_no + lat : last_due + 1;
      r.data = use_fixed ? fixed_data : $urandom;
      r.err  = force_err || ($urandom_range(99) < err_pct);
      last_due = r.due;
      memq.push_back(r);
    end
    cyc_no++;
    @(negedge clk);
    check("wb_ack", wb_ack, n_ack);
    check("wb_err", wb_err, n_err);
    check("wb_dat_o", wb_dat_o, exp_dat);
    ack_cnt += int'(wb_ack);
    err_cnt += int'(wb_err);
  endtask

  task automatic drive(input bit cyc, input bit stb, input bit we, input logic [31:0] adr);
    wb_cyc = cyc; wb_stb = stb; wb_we = we; wb_adr = adr;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    wb_stb = 0;
    while ((owed != 0 || stale != 0 || memq.size() != 0) && n < 40) begin
      step(); n++;
    end
    check(tag, n < 40, 1'b1);
  endtask

  initial begin
    int a0, e0, n, i;
    rst_n = 0; mem_gnt = 1; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    drive(0, 0, 0, '0); wb_sel = 4'hF; wb_dat_i = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ack", wb_ack, 1'b0);
    check("rst_err", wb_err, 1'b0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_stall_gnt1", wb_stall, 1'b0);
    mem_gnt = 0; #1;
    check("rst_stall_gnt0", wb_stall, 1'b1);
    mem_gnt = 1; #1;
    rst_n = 1;
    @(negedge clk);

    // single read, memory latency 1
    use_fixed = 1; fixed_data = 32'hDEADBEEF; a0 = ack_cnt;
    drive(1, 1, 0, 32'h100);
    step(); check("sr_accept", last_acc, 1'b1);
    wb_stb = 0; step(); step();
    check("sr_ack_count", ack_cnt - a0, 1);
    check("sr_data", wb_dat_o, 32'hDEADBEEF);
    use_fixed = 0;

    // write with partial select
    a0 = ack_cnt;
    drive(1, 1, 1, 32'h200); wb_sel = 4'b0011; wb_dat_i = 32'h12345678; #1;
    check("wr_fwd", {mem_req, mem_we, mem_be, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h12345678});
    step(); wb_stb = 0; wb_sel = 4'hF; step(); step();
    check("wr_ack_count", ack_cnt - a0, 1);

    // error termination
    a0 = ack_cnt; e0 = err_cnt; force_err = 1;
    drive(1, 1, 0, 32'h300); step(); force_err = 0;
    wb_stb = 0; step(); step(); step();
    check("err_count", err_cnt - e0, 1);
    check("err_no_ack", ack_cnt - a0, 0);

    // pipelined burst of four, latency 3
    lat_min = 3; lat_max = 3; a0 = ack_cnt; i = 0; n = 0;
    while (i < 4 && n < 30) begin
      drive(1, 1, 0, 32'h400 + 32'(i * 4)); step();
      if (last_acc) i++;
      n++;
    end
    check("burst_accepts", i, 4);
    drain("burst_drain");
    check("burst_ack_count", ack_cnt - a0, 4);

    // abort with two reads in flight, then a fresh cycle
    a0 = ack_cnt; e0 = err_cnt; i = 0; n = 0;
    while (i < 2 && n < 10) begin
      drive(1, 1, 0, 32'h500); step();
      if (last_acc) i++;
      n++;
    end
    drive(0, 0, 0, '0); step();
    use_fixed = 1; fixed_data = 32'hCAFEF00D; n = 0;
    drive(1, 1, 0, 32'h600);
    do begin step(); n++; end while (!last_acc && n < 20);
    check("abort_new_accept", last_acc, 1'b1);
    use_fixed = 0;
    drain("abort_drain");
    check("abort_ack_count", ack_cnt - a0, 1);
    check("abort_err_count", err_cnt - e0, 0);
    check("abort_data", wb_dat_o, 32'hCAFEF00D);

    // randomized traffic including aborts, stalls and errors
    lat_min = 1; lat_max = 4; err_pct = 12;
    for (int k = 0; k < 500; k++) begin
      wb_cyc   = ($urandom_range(9) != 0);
      wb_stb   = wb_cyc && ($urandom_range(9) < 6);
      wb_we    = 1'($urandom_range(1));
      wb_sel   = 4'($urandom);
      wb_adr   = $urandom;
      wb_dat_i = $urandom;
      mem_gnt  = ($urandom_range(3) != 0);
      step();
    end
    mem_gnt = 1; wb_cyc = 1;
    drain("rand_drain");
    err_pct = 0;

    // reset with two reads outstanding
    lat_min = 4; lat_max = 4; i = 0; n = 0;
    while (i < 2 && n < 10) begin
      drive(1, 1, 0, 32'h700); step();
      if (last_acc) i++;
      n++;
    end
    #2 rst_n = 0; mem_rvalid = 0;
    #1;
    check("mid_rst_outs", {wb_ack, wb_err, wb_dat_o}, 34'h0);
    memq.delete(); owed = 0; stale = 0; exp_dat = '0; last_due = -1;
    drive(0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1; mem_gnt = 1;
    step();
    lat_min = 1; lat_max = 2; a0 = ack_cnt;
    drive(1, 1, 0, 32'h800); step();
    check("post_rst_accept", last_acc, 1'b1);
    drain("post_rst_drain");
    check("post_rst_ack", ack_cnt - a0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
